// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending CPU stores drained to data RAM in idle/stall cycles.
// Define STORE_FWD_EN to forward fully covered loads from the youngest matching entry.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_readEnable,
    input  logic        i_writeEnable,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_storeData,
    output logic [31:0] o_loadData,
    output logic        o_stall,
    output logic        o_empty,
    output logic        o_ramReadEnable,
    output logic        o_ramWriteEnable,
    output logic [31:0] o_ramAddr,
    output logic [3:0]  o_ramSel,
    output logic [31:0] o_ramStoreData,
    input  logic [31:0] i_ramLoadData
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] addr_q [DEPTH];
    logic [31:0] addr_d [DEPTH];
    logic [3:0]  sel_q  [DEPTH];
    logic [3:0]  sel_d  [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];

    logic          hit;
    logic [PW-1:0] hit_idx;
    logic [PW-1:0] scan_idx;

    logic req;
    logic full;
    logic stall;
    logic accept;
    logic drain;
    logic ram_rd;
    logic fwd;

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int a = 0; a < DEPTH; a++) begin
            scan_idx = head_q + PW'(a);
            if ((CW'(a) < count_q) &&
                (addr_q[scan_idx][31:2] == i_addr[31:2])) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    always_comb begin
        req    = i_readEnable | i_writeEnable;
        full   = (count_q == CW'(DEPTH));
        stall  = 1'b0;
        ram_rd = 1'b0;
        fwd    = 1'b0;
        if (i_writeEnable) begin
            stall = full;
        end else if (i_readEnable) begin
            if (!hit) begin
                ram_rd = 1'b1;
            end else begin
`ifdef STORE_FWD_EN
                if ((i_sel & ~sel_q[hit_idx]) == 4'b0000) begin
                    fwd = 1'b1;
                end else begin
                    stall = 1'b1;
                end
`else
                stall = 1'b1;
`endif
            end
        end
        if (rst) begin
            stall  = 1'b0;
            ram_rd = 1'b0;
            fwd    = 1'b0;
        end
        accept = i_writeEnable & ~stall & ~rst;
        drain  = (~req | stall) & (count_q != '0) & ~rst;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (accept) begin
            addr_d[tail_q] = i_addr;
            sel_d[tail_q]  = i_sel;
            data_d[tail_q] = i_storeData;
            tail_d         = tail_q + 1'b1;
        end
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        // Simultaneous drain and enqueue leave the occupancy unchanged.
        case ({accept, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        o_stall          = stall;
        o_empty          = rst | (count_q == '0);
        o_ramReadEnable  = ram_rd;
        o_ramWriteEnable = drain;
        o_ramAddr        = '0;
        o_ramSel         = '0;
        o_ramStoreData   = '0;
        o_loadData       = '0;
        if (drain) begin
            o_ramAddr      = addr_q[head_q];
            o_ramSel       = sel_q[head_q];
            o_ramStoreData = data_q[head_q];
        end else if (ram_rd) begin
            o_ramAddr = i_addr;
            o_ramSel  = i_sel;
        end
        if (ram_rd) begin
            o_loadData = i_ramLoadData;
        end else if (fwd) begin
            o_loadData = data_q[hit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        sel_q  <= sel_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
// Follows STORE_FWD_EN the same way as the design build.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_readEnable;
    logic        i_writeEnable;
    logic [31:0] i_addr;
    logic [3:0]  i_sel;
    logic [31:0] i_storeData;
    logic [31:0] o_loadData;
    logic        o_stall;
    logic        o_empty;
    logic        o_ramReadEnable;
    logic        o_ramWriteEnable;
    logic [31:0] o_ramAddr;
    logic [3:0]  o_ramSel;
    logic [31:0] o_ramStoreData;
    logic [31:0] i_ramLoadData;

    int n_vec = 0;
    int n_err = 0;

    ent_t        q[$];
    logic [31:0] ref_ram [256];
    logic [31:0] dut_ram [256];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_readEnable     (i_readEnable),
        .i_writeEnable    (i_writeEnable),
        .i_addr           (i_addr),
        .i_sel            (i_sel),
        .i_storeData      (i_storeData),
        .o_loadData       (o_loadData),
        .o_stall          (o_stall),
        .o_empty          (o_empty),
        .o_ramReadEnable  (o_ramReadEnable),
        .o_ramWriteEnable (o_ramWriteEnable),
        .o_ramAddr        (o_ramAddr),
        .o_ramSel         (o_ramSel),
        .o_ramStoreData   (o_ramStoreData),
        .i_ramLoadData    (i_ramLoadData)
    );

    // Data RAM seen by the DUT: combinational read, byte-lane write.
    always_comb i_ramLoadData = dut_ram[o_ramAddr[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) dut_ram[k] <= '0;
        end else if (o_ramWriteEnable) begin
            for (int b = 0; b < 4; b++)
                if (o_ramSel[b])
                    dut_ram[o_ramAddr[9:2]][8*b +: 8] <= o_ramStoreData[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; checks outputs against the model, then advances it.
    task automatic step(input logic r, input logic re, input logic we,
                        input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic stalled);
        int          cnt;
        int          hi;
        logic        stl;
        logic        rre;
        logic        drn;
        logic        ld_chk;
        logic [31:0] eld;
        @(negedge clk);
        rst           = r;
        i_readEnable  = re;
        i_writeEnable = we;
        i_addr        = a;
        i_sel         = s;
        i_storeData   = d;
        #1;
        stalled = 1'b0;
        if (r) begin
            chk("rst_stall", {31'b0, o_stall}, 32'd0);
            chk("rst_ram_re", {31'b0, o_ramReadEnable}, 32'd0);
            chk("rst_ram_we", {31'b0, o_ramWriteEnable}, 32'd0);
            chk("rst_load", o_loadData, 32'd0);
            chk("rst_empty", {31'b0, o_empty}, 32'd1);
            @(posedge clk);
            q.delete();
            for (int k = 0; k < 256; k++) ref_ram[k] = '0;
            return;
        end
        cnt = q.size();
        hi  = -1;
        for (int k = 0; k < cnt; k++)
            if (q[k].a[31:2] == a[31:2]) hi = k;
        stl    = 1'b0;
        rre    = 1'b0;
        ld_chk = 1'b0;
        eld    = '0;
        if (we) begin
            stl = (cnt == DEPTH);
        end else if (re) begin
            if (hi < 0) begin
                rre    = 1'b1;
                ld_chk = 1'b1;
                eld    = ref_ram[a[9:2]];
            end else begin
`ifdef STORE_FWD_EN
                if ((s & ~q[hi].s) == 4'b0000) begin
                    ld_chk = 1'b1;
                    eld    = q[hi].d;
                end else begin
                    stl = 1'b1;
                end
`else
                stl = 1'b1;
`endif
            end
        end
        drn = (!(re || we) || stl) && (cnt > 0);
        chk("stall", {31'b0, o_stall}, {31'b0, stl});
        chk("ram_re", {31'b0, o_ramReadEnable}, {31'b0, rre});
        chk("ram_we", {31'b0, o_ramWriteEnable}, {31'b0, drn});
        chk("empty", {31'b0, o_empty}, {31'b0, (cnt == 0)});
        if (ld_chk) chk("load_data", o_loadData, eld);
        if (!(re || we) && cnt == 0) chk("idle_load", o_loadData, 32'd0);
        if (drn) begin
            chk("drain_addr", o_ramAddr, q[0].a);
            chk("drain_sel", {28'b0, o_ramSel}, {28'b0, q[0].s});
            chk("drain_data", o_ramStoreData, q[0].d);
        end
        if (rre) begin
            chk("rd_addr", o_ramAddr, a);
            chk("rd_sel", {28'b0, o_ramSel}, {28'b0, s});
        end
        @(posedge clk);
        if (drn) begin
            for (int b = 0; b < 4; b++)
                if (q[0].s[b]) ref_ram[q[0].a[9:2]][8*b +: 8] = q[0].d[8*b +: 8];
            void'(q.pop_front());
        end
        if (we && !stl) q.push_back('{a: a, s: s, d: d});
        stalled = stl;
    endtask

    // Holds a request while the model says the CPU is stalled; returns cycles used.
    task automatic req(input logic re, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, output int cyc);
        logic st;
        cyc = 0;
        do begin
            step(1'b0, re, we, a, s, d, st);
            cyc++;
        end while (st && cyc < 40);
        if (st) begin
            n_err++;
            $error("FAIL hold_timeout observed=%0d cycles expected=<40", cyc);
        end
    endtask

    task automatic idle(input int n);
        logic st;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, st);
    endtask

    initial begin
        logic st;
        int   cyc;
        int   op;
        rst           = 1'b1;
        i_readEnable  = 1'b0;
        i_writeEnable = 1'b0;
        i_addr        = '0;
        i_sel         = '0;
        i_storeData   = '0;
        for (int k = 0; k < 256; k++) ref_ram[k] = '0;

        step(1'b1, 1'b0, 1'b0, '0, '0, '0, st);
        step(1'b1, 1'b0, 1'b1, 32'h8, 4'hF, 32'hDEAD, st);
        idle(1);

        // Full buffer: fifth store stalls exactly one cycle.
        for (int k = 0; k < 4; k++)
            req(1'b0, 1'b1, 32'h10 + 32'(4*k), 4'hF, 32'hA0 + 32'(k), cyc);
        req(1'b0, 1'b1, 32'h20, 4'hF, 32'hA4, cyc);
        chk("full_stall_cycles", cyc, 2);
        idle(6);

        // Reset discards buffered stores.
        for (int k = 0; k < 3; k++)
            req(1'b0, 1'b1, 32'h30 + 32'(4*k), 4'hF, 32'hB0 + 32'(k), cyc);
        step(1'b1, 1'b0, 1'b1, 32'h3C, 4'hF, 32'hBB, st);
        idle(2);

        // Full-cover load after store.
        req(1'b0, 1'b1, 32'h40, 4'hF, 32'hAABBCCDD, cyc);
        req(1'b1, 1'b0, 32'h40, 4'h3, '0, cyc);
`ifdef STORE_FWD_EN
        chk("cover_load_cycles", cyc, 1);
`else
        chk("cover_load_cycles", cyc, 2);
`endif
        idle(2);

        // Partial cover always stalls until drained.
        req(1'b0, 1'b1, 32'h40, 4'h1, 32'h00000011, cyc);
        req(1'b1, 1'b0, 32'h40, 4'hF, '0, cyc);
        chk("partial_load_cycles", cyc, 2);

        // Youngest match governs.
        req(1'b0, 1'b1, 32'h80, 4'hF, 32'h11111111, cyc);
        req(1'b0, 1'b1, 32'h80, 4'hF, 32'h22222222, cyc);
        req(1'b1, 1'b0, 32'h80, 4'hF, '0, cyc);
`ifdef STORE_FWD_EN
        chk("youngest_cycles", cyc, 1);
`else
        chk("youngest_cycles", cyc, 3);
`endif
        idle(3);
        chk("ram_0x80", dut_ram[8'h20], 32'h22222222);

        // Miss with entries pending: no drain that cycle.
        req(1'b0, 1'b1, 32'h100, 4'hF, 32'h12345678, cyc);
        idle(2);
        req(1'b0, 1'b1, 32'h44, 4'hF, 32'h55, cyc);
        req(1'b1, 1'b0, 32'h100, 4'hF, '0, cyc);
        chk("miss_cycles", cyc, 1);
        idle(2);

        for (int it = 0; it < 400; it++) begin
            op = int'($urandom_range(0, 99));
            if (op < 2) begin
                step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 32'h40, 4'hF, $urandom, st);
            end else if (op < 25) begin
                idle(1);
            end else if (op < 60) begin
                req(1'b1, 1'b0, 32'h40 + 32'($urandom_range(0, 31)),
                    4'($urandom_range(1, 15)), '0, cyc);
            end else begin
                req(1'b0, 1'b1, 32'h40 + 32'($urandom_range(0, 31)),
                    4'($urandom_range(1, 15)), $urandom, cyc);
            end
        end
        idle(DEPTH + 2);
        for (int k = 0; k < 256; k++)
            chk($sformatf("ram[%0d]", k), dut_ram[k], ref_ram[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_readEnable  input  1  CPU load request this cycle.
REQ-005 i_writeEnable  input  1  CPU store request this cycle; never asserted together with i_readEnable.
REQ-006 i_addr  input  32  CPU byte address; word index is bits [31:2].
REQ-007 i_sel  input  4  CPU byte-lane select.
REQ-008 i_storeData  input  32  CPU store data.
REQ-009 o_loadData  output  32  load result to CPU, valid in the request cycle when o_stall=0.
REQ-010 o_stall  output  1  CPU SHALL hold its request unchanged while high.
REQ-011 o_empty  output  1  high when no entries are buffered.
REQ-012 o_ramReadEnable, o_ramWriteEnable  output  1 each  data-RAM strobes.
REQ-013 o_ramAddr  output  32, o_ramSel  output  4, o_ramStoreData  output  32  data-RAM request.
REQ-014 i_ramLoadData  input  32  data-RAM combinational read data.

Function
REQ-015 Entries SHALL be held as a FIFO of {addr, sel, data}, with head and tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-016 An accepted store SHALL enqueue at the tail on the clock edge and SHALL NOT write the RAM in that cycle.
REQ-017 A store SHALL be accepted when count<DEPTH; when count==DEPTH, o_stall SHALL be 1 and the store SHALL be accepted on the first cycle count<DEPTH.
REQ-018 A drain cycle is any cycle with (no CPU request, or o_stall=1) and count>0.
REQ-019 In a drain cycle, o_ramWriteEnable=1, the head entry SHALL drive addr/sel/data, and head SHALL advance at the edge.
REQ-020 A drain and an enqueue in the same edge SHALL leave count unchanged.
REQ-021 A load is a hit when any valid entry has addr[31:2] equal to i_addr[31:2]; the youngest matching entry governs the load.
REQ-022 On a load miss, o_stall=0, o_ramReadEnable=1, o_ramAddr/o_ramSel SHALL be driven from the CPU, and o_loadData=i_ramLoadData, all in the same cycle (zero latency).
REQ-023 A load hit SHALL be handled according to REQ-030/REQ-031; during a hit stall o_ramReadEnable=0 and draining continues.
REQ-024 When no request and count==0, all RAM strobes SHALL be 0 and o_loadData=0.
REQ-025 o_empty SHALL equal (count==0), registered-state derived, with no combinational path from the CPU inputs.

Reset
REQ-026 When rst is high at an edge, head, tail and count SHALL clear to 0 and all buffered stores SHALL be discarded, including when reset arrives mid-stall or mid-drain.
REQ-027 While rst is high: o_stall=0, o_ramReadEnable=0, o_ramWriteEnable=0, o_loadData=0, o_empty=1, and no enqueue occurs.

Configuration
REQ-028 The macro STORE_FWD_EN SHALL select store-to-load forwarding.
REQ-029 The unit SHALL use the full load sel when judging byte coverage for a hit.
REQ-030 With STORE_FWD_EN defined, if the youngest matching entry's sel covers the load sel ((i_sel & ~entry.sel)==0), then o_loadData=entry.data, o_stall=0 and no RAM read occurs; otherwise the load stalls as in REQ-031.
REQ-031 Without STORE_FWD_EN, any hit SHALL set o_stall=1 until no matching entry remains, then the load completes as a miss.

Verification
REQ-032 Reset with 3 buffered stores, then an idle cycle -> o_empty=1, no RAM write, o_ramWriteEnable=0.
REQ-033 Stores to 0x10, 0x14, 0x18, 0x1C, 0x20 back-to-back with DEPTH=4 -> o_stall=1 on the 5th store for exactly one cycle, the RAM is written at 0x10 in that cycle, and the 5th store is accepted on the next cycle.
REQ-034 Store 0xAABBCCDD sel=1111 to 0x40, then load 0x40 sel=0011 -> with STORE_FWD_EN, o_loadData=0xAABBCCDD in the same cycle with o_stall=0; without it, o_stall=1 for one cycle, then the RAM read returns the drained value.
REQ-035 Store sel=0001 to 0x40, then load 0x40 sel=1111 -> o_stall=1 until the entry drains, then o_ramReadEnable=1 at 0x40 (both configurations).
REQ-036 Stores 0x11111111 then 0x22222222 to 0x80, then load 0x80 with STORE_FWD_EN -> 0x22222222; after drain the RAM holds 0x22222222.
REQ-037 Load miss at 0x100 with RAM data 0x12345678 -> same-cycle o_loadData=0x12345678 and o_ramWriteEnable=0 despite count>0.
